mac_result_uart_tx: RTL and testbench

Output stage that sits directly downstream of the accumulator FSM. It takes 8-bit accumulator results through a valid/ready handshake and buffers them in a small FIFO. It then transmits each result LSB-first on a single UART-style serial line (8N1) so results can be read off-chip through one pin. It also reports its occupancy and a sticky overflow flag.

---
 rtl/mac_result_uart_tx.sv | 114 +++++++++++
 tb/tb_mac_result_uart_tx.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/mac_result_uart_tx.sv
// mac_result_uart_tx: FIFO-buffered LSB-first 8N1 serial transmitter for accumulator results.
// Defining MAC_TX_PARITY_EN inserts an even-parity bit before STOP.
module mac_result_uart_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ena,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       tx,
  output logic       busy,
  output logic [3:0] fifo_count,
  output logic       overflow
);
  localparam int AW = $clog2(FIFO_DEPTH);
`ifdef MAC_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif
  state_t state, state_n;
  logic [7:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [7:0] baud, baud_n, shift, shift_n;
  logic [2:0] idx, idx_n;
  logic full, push, pop, last, tx_n;
  assign full = fifo_count == 4'(FIFO_DEPTH);
  assign in_ready = ena & !full;
  assign push = in_valid & in_ready;
  assign last = baud == 8'(CLKS_PER_BIT - 1);
`ifdef MAC_TX_PARITY_EN
  logic par;
  always_ff @(posedge clk)
    if (rst) par <= 1'b0;
    else if (ena & pop) par <= ^mem[rptr];
`endif
  always_comb begin
    state_n = state;
    baud_n = baud + 8'd1;
    idx_n = idx;
    shift_n = shift;
    pop = 1'b0;
    case (state)
      IDLE: begin
        baud_n = 8'd0;
        if (fifo_count != 4'd0) begin
          pop = 1'b1;
          shift_n = mem[rptr];
          state_n = START;
        end
      end
      START: if (last) begin
        baud_n = 8'd0;
        idx_n = 3'd0;
        state_n = DATA;
      end
      DATA: if (last) begin
        baud_n = 8'd0;
        shift_n = shift >> 1;
        idx_n = idx + 3'd1;
`ifdef MAC_TX_PARITY_EN
        if (idx == 3'd7) state_n = PARITY;
`else
        if (idx == 3'd7) state_n = STOP;
`endif
      end
`ifdef MAC_TX_PARITY_EN
      PARITY: if (last) begin
        baud_n = 8'd0;
        state_n = STOP;
      end
`endif
      STOP: if (last) begin
        baud_n = 8'd0;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
`ifdef MAC_TX_PARITY_EN
    tx_n = state_n == START ? 1'b0 : state_n == DATA ? shift_n[0] : state_n == PARITY ? par : 1'b1;
`else
    tx_n = state_n == START ? 1'b0 : state_n == DATA ? shift_n[0] : 1'b1;
`endif
  end
  always_ff @(posedge clk)
    if (push) mem[wptr] <= in_data;
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      baud <= 8'd0;
      idx <= 3'd0;
      shift <= 8'd0;
      wptr <= '0;
      rptr <= '0;
      fifo_count <= 4'd0;
      overflow <= 1'b0;
      tx <= 1'b1;
      busy <= 1'b0;
    end else if (ena) begin
      state <= state_n;
      baud <= baud_n;
      idx <= idx_n;
      shift <= shift_n;
      tx <= tx_n;
      busy <= state_n != IDLE;
      if (push) wptr <= wptr + 1'b1;
      if (pop) rptr <= rptr + 1'b1;
      fifo_count <= fifo_count + 4'(push) - 4'(pop);
      if (in_valid & full) overflow <= 1'b1;
    end
endmodule

// File: tb/tb_mac_result_uart_tx.sv
// tb_mac_result_uart_tx: directed stimulus with a serial-line decoding scoreboard.
module tb_mac_result_uart_tx;
  localparam int C = 4;
`ifdef MAC_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  logic clk = 0, rst = 1, ena = 0, in_valid = 0;
  logic [7:0] in_data = 0;
  logic in_ready, tx, busy, overflow;
  logic [3:0] fifo_count;
  int checks = 0, fails = 0;
  logic [7:0] sb[$];
  mac_result_uart_tx #(.CLKS_PER_BIT(C), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .ena(ena), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .tx(tx), .busy(busy), .fifo_count(fifo_count), .overflow(overflow)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic step(input int k);
    repeat (k) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic wait_idle();
    int k = 0;
    while ((busy || fifo_count != 0) && k < 3000) begin
      step(1);
      k++;
    end
    chk("drain_timeout", k < 3000, 1);
    step(2);
  endtask
  task automatic wait_busy_low();
    int k = 0;
    while (busy && k < 200) begin
      step(1);
      k++;
    end
    chk("busy_fall_timeout", k < 200, 1);
  endtask
  // Decoder advances only on enabled edges so frozen frames still decode correctly.
  logic en_q = 0;
  logic [10:0] fr;
  int n = 0;
  bit active = 0;
  always @(posedge clk) en_q <= ena;
  always @(negedge clk) begin
    if (rst) active = 0;
    else if (!active) begin
      if (tx === 1'b0) begin
        active = 1;
        n = 0;
      end
    end else if (en_q) begin
      n++;
      if (n % C == C / 2) begin
        fr[n / C] = tx;
        if (n / C == NB - 1) begin
          active = 0;
          chk("start_bit", fr[0], 0);
          chk("stop_bit", fr[NB-1], 1);
          chk("frame_expected", sb.size() != 0, 1);
          if (sb.size() != 0) begin
            chk("rx_byte", fr[8:1], sb[0]);
`ifdef MAC_TX_PARITY_EN
            chk("rx_parity", fr[9], ^sb[0]);
`endif
            void'(sb.pop_front());
          end
        end
      end
    end
  end
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int bc, g;
    bit quiet;
    ena = 1;
    step(2);
    chk("rst_tx", tx, 1);
    chk("rst_busy", busy, 0);
    chk("rst_count", fifo_count, 0);
    chk("rst_overflow", overflow, 0);
    rst = 0;
    chk("rst_in_ready", in_ready, 1);
    // single byte
    in_data = 8'h5A; in_valid = 1; sb.push_back(8'h5A);
    step(1);
    in_valid = 0;
    chk("push_count", fifo_count, 1);
    chk("push_busy", busy, 0);
    step(1);
    chk("start_tx", tx, 0);
    chk("start_busy", busy, 1);
    chk("pop_count", fifo_count, 0);
    bc = 0;
    while (busy && bc < 200) begin
      step(1);
      bc++;
    end
    chk("busy_len", bc, NB * C);
    step(3);
    chk("single_sb_empty", sb.size(), 0);
    // ena low: nothing accepted
    ena = 0; in_valid = 1; in_data = 8'h77;
    step(3);
    chk("ena0_in_ready", in_ready, 0);
    chk("ena0_count", fifo_count, 0);
    chk("ena0_overflow", overflow, 0);
    in_valid = 0; ena = 1;
    // fill while a frame is in flight, then overflow
    in_data = 8'hA5; in_valid = 1; sb.push_back(8'hA5);
    step(1);
    in_valid = 0;
    step(1);
    chk("fill_busy", busy, 1);
    for (int i = 1; i <= 5; i++) begin
      in_data = 8'(i); in_valid = 1;
      chk("fill_in_ready", in_ready, i <= 4);
      if (i <= 4) sb.push_back(8'(i));
      step(1);
      chk("fill_count", fifo_count, i < 4 ? i : 4);
    end
    in_valid = 0;
    chk("overflow_set", overflow, 1);
    chk("full_in_ready", in_ready, 0);
    wait_idle();
    chk("fill_sb_empty", sb.size(), 0);
    chk("overflow_sticky", overflow, 1);
    rst = 1;
    step(1);
    rst = 0;
    chk("overflow_cleared", overflow, 0);
    // back-to-back
    in_data = 8'hFF; in_valid = 1; sb.push_back(8'hFF);
    step(1);
    in_data = 8'h00; sb.push_back(8'h00);
    step(1);
    in_valid = 0;
    wait_busy_low();
    g = 0;
    while (tx && g < 50) begin
      g++;
      step(1);
    end
    chk("idle_gap", g, 1);
    chk("second_busy", busy, 1);
    wait_idle();
    chk("b2b_sb_empty", sb.size(), 0);
    // freeze mid data bit 3
    in_data = 8'hC3; in_valid = 1; sb.push_back(8'hC3);
    step(1);
    in_valid = 0;
    step(1 + 4 * C + 1);
    chk("bit3_level", tx, 0);
    ena = 0;
    step(7);
    chk("freeze_tx", tx, 0);
    chk("freeze_busy", busy, 1);
    chk("freeze_in_ready", in_ready, 0);
    ena = 1;
    bc = 0;
    while (busy && bc < 200) begin
      step(1);
      bc++;
    end
    chk("freeze_remaining", bc, NB * C - (4 * C + 1));
    wait_idle();
    chk("freeze_sb_empty", sb.size(), 0);
    // reset during data bit 5 with two queued
    in_data = 8'h3C; in_valid = 1;
    step(1);
    in_data = 8'h11;
    step(1);
    in_data = 8'h22;
    step(1);
    in_valid = 0;
    chk("queued_two", fifo_count, 2);
    step(6 * C);
    chk("bit5_busy", busy, 1);
    rst = 1;
    step(1);
    chk("abort_tx", tx, 1);
    chk("abort_busy", busy, 0);
    chk("abort_count", fifo_count, 0);
    chk("abort_overflow", overflow, 0);
    rst = 0;
    quiet = 1;
    repeat (150) begin
      step(1);
      if (tx !== 1'b1 || busy !== 1'b0) quiet = 0;
    end
    chk("abort_quiet", quiet, 1);
    // push and pop on the same edge, then pointer wrap
    in_data = 8'h81; in_valid = 1; sb.push_back(8'h81);
    step(1);
    in_data = 8'h42; sb.push_back(8'h42);
    step(1);
    in_data = 8'h24; sb.push_back(8'h24);
    step(1);
    in_valid = 0;
    chk("pp_pre_count", fifo_count, 2);
    wait_busy_low();
    in_data = 8'h99; in_valid = 1; sb.push_back(8'h99);
    step(1);
    in_valid = 0;
    chk("pushpop_count", fifo_count, 2);
    chk("pushpop_busy", busy, 1);
    in_data = 8'h55; in_valid = 1; sb.push_back(8'h55);
    step(1);
    in_valid = 0;
    chk("wrap_count", fifo_count, 3);
    wait_idle();
    chk("wrap_sb_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
